// File: rtl/alu_seq_pipe_if.sv
// Handshake bundle for alu_seq_pipe: operand/opcode request on the input side,
// result plus flags on the output side.
interface alu_seq_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic [2:0]       opc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_w;
  logic             zer;
  logic             neg;
  logic             cout;

  // Upstream/downstream side (operand fetch drives requests, writeback drives out_ready)
  modport master (
    output in_valid, in_a, in_b, in_c, opc, out_ready,
    input  in_ready, out_valid, out_w, zer, neg, cout
  );

  // ALU side
  modport slave (
    input  in_valid, in_a, in_b, in_c, opc, out_ready,
    output in_ready, out_valid, out_w, zer, neg, cout
  );
endinterface

// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe: registered WIDTH-bit ALU with valid/ready on both sides.
// Ops 000-110 complete in one cycle at full throughput; the result register
// holds until out_ready. Optional feature macro ALU_MUL_EN turns opc 111 into
// a shift-add multiply (one partial product per cycle, WIDTH busy cycles);
// without it opc 111 returns zero in one cycle and no multiplier exists.
module alu_seq_pipe #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_pipe_if.slave bus
);
  localparam int H = WIDTH / 2;

  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic             c;
  } res_t;

  logic             out_valid;
  logic [WIDTH-1:0] out_w;
  logic             zer, neg, cout;
  logic             in_ready;
  logic             accept;
  res_t             alu;
  logic [WIDTH:0]   sum;

  assign bus.out_valid = out_valid;
  assign bus.out_w     = out_w;
  assign bus.zer       = zer;
  assign bus.neg       = neg;
  assign bus.cout      = cout;
  assign bus.in_ready  = in_ready;
  assign accept        = bus.in_valid && in_ready;

  // Single-cycle datapath; arith ops share one WIDTH+1 sum whose top bit is cout
  always_comb begin
    sum   = '0;
    alu.w = '0;
    alu.c = 1'b0;
    case (bus.opc)
      3'b000: begin
        sum = {1'b0, ~bus.in_a} + (WIDTH+1)'(1);
        alu = '{w: sum[WIDTH-1:0], c: sum[WIDTH]};
      end
      3'b001: begin
        sum = {1'b0, bus.in_a} + (WIDTH+1)'(1);
        alu = '{w: sum[WIDTH-1:0], c: sum[WIDTH]};
      end
      3'b010: begin
        sum = {1'b0, bus.in_a} + {1'b0, bus.in_b} + (WIDTH+1)'(bus.in_c);
        alu = '{w: sum[WIDTH-1:0], c: sum[WIDTH]};
      end
      3'b011: begin
        sum = {1'b0, bus.in_a} + {2'b00, bus.in_b[WIDTH-1:1]};
        alu = '{w: sum[WIDTH-1:0], c: sum[WIDTH]};
      end
      3'b100:  alu.w = bus.in_a & bus.in_b;
      3'b101:  alu.w = bus.in_a | bus.in_b;
      3'b110:  alu.w = {bus.in_a[H-1:0], bus.in_b[H-1:0]};
      default: alu.w = '0;  // 111: multiplier result comes from the FSM path
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready_q());
  assign acc_nxt  = mplier[0] ? acc + mcand : acc;

  function automatic logic out_ready_q();
    return bus.out_ready;
  endfunction

  // FSM + result register: single-cycle ops load directly, MUL iterates in BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_w     <= '0;
      zer       <= 1'b0;
      neg       <= 1'b0;
      cout      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.opc == 3'b111) begin
              state  <= BUSY;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.in_a};
              mplier <= bus.in_b;
              cnt    <= '0;
            end else begin
              out_valid <= 1'b1;
              out_w     <= alu.w;
              zer       <= (alu.w == '0);
              neg       <= alu.w[WIDTH-1];
              cout      <= alu.c;
            end
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Last partial product: publish low half, flag any lost high bits
          if (cnt == LAST) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_w     <= acc_nxt[WIDTH-1:0];
            zer       <= (acc_nxt[WIDTH-1:0] == '0);
            neg       <= acc_nxt[WIDTH-1];
            cout      <= |acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = !out_valid || bus.out_ready;

  // Result register: every op (111 included, returning zero) completes in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_w     <= '0;
      zer       <= 1'b0;
      neg       <= 1'b0;
      cout      <= 1'b0;
    end else begin
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_w     <= alu.w;
        zer       <= (alu.w == '0);
        neg       <= alu.w[WIDTH-1];
        cout      <= alu.c;
      end
    end
  end
`endif

endmodule
